// File: rtl/ir_link_arbiter.sv
// Half-duplex arbiter for the shared IrDA optical channel.
// Grants the channel to RX or TX, masks TX echo and enforces a turnaround guard.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | channel free; receive activity wins over a pending tx_req
// RX    | receiver owns the channel; tx_req held pending
// TX    | transmitter owns the channel; line masked, timeout running
// GUARD | turnaround interval; masked only when entered from TX
module ir_link_arbiter #(
    parameter int TURNAROUND_CYCLES = 10416,
    parameter int TX_TIMEOUT        = 600000,
    parameter int CNT_W             = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_line,
    input  logic       rx_busy,
    input  logic       tx_req,
    input  logic       tx_done,
    output logic       rx_line_gated,
    output logic       tx_grant,
    output logic       tx_active,
    output logic       collision,
    output logic       tx_timeout,
    output logic [1:0] link_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RX    = 2'b01,
        S_TX    = 2'b10,
        S_GUARD = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND_CYCLES - 1);
    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             guard_from_tx, guard_from_tx_nxt;
    logic             grant_nxt, timeout_nxt, collision_nxt;
    logic             rx_meta, rx_s, rx_p;
    logic             fall;
    logic             masked;

    assign fall   = rx_p & ~rx_s;
    assign masked = (state == S_TX) || ((state == S_GUARD) && guard_from_tx);

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_p          <= 1'b1;
            state         <= S_IDLE;
            cnt           <= '0;
            guard_from_tx <= 1'b0;
            tx_grant      <= 1'b0;
            tx_timeout    <= 1'b0;
            collision     <= 1'b0;
        end else begin
            rx_meta       <= rx_line;
            rx_s          <= rx_meta;
            rx_p          <= rx_s;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            guard_from_tx <= guard_from_tx_nxt;
            tx_grant      <= grant_nxt;
            tx_timeout    <= timeout_nxt;
            collision     <= collision_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        guard_from_tx_nxt = guard_from_tx;
        grant_nxt         = 1'b0;
        timeout_nxt       = 1'b0;
        collision_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s || rx_busy) begin
                    state_nxt = S_RX;
                end else if (tx_req) begin
                    state_nxt = S_TX;
                    cnt_nxt   = '0;
                    grant_nxt = 1'b1;
                end
            end
            S_RX: begin
                if (!rx_busy && rx_s) begin
                    state_nxt         = S_GUARD;
                    guard_from_tx_nxt = 1'b0;
                    cnt_nxt           = '0;
                end
            end
            S_TX: begin
                collision_nxt = fall;
                // tx_done on the terminal cycle is a normal completion, not a timeout
                if (tx_done) begin
                    state_nxt         = S_GUARD;
                    guard_from_tx_nxt = 1'b1;
                    cnt_nxt           = '0;
                end else if (cnt == TX_LAST) begin
                    state_nxt         = S_GUARD;
                    guard_from_tx_nxt = 1'b1;
                    cnt_nxt           = '0;
                    timeout_nxt       = 1'b1;
                end
            end
            S_GUARD: begin
                if (!guard_from_tx && !rx_s) begin
                    state_nxt = S_RX;
                    cnt_nxt   = '0;
                end else if (cnt == TURN_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign tx_active     = (state == S_TX);
    assign link_state    = state;
    assign rx_line_gated = masked | rx_s;

endmodule
